vision_test_ctrl: RTL and testbench

Sequencing controller for the E-chart vision test. It runs the level-stepping state machine that picks each optotype's level and direction, judges each key response, and produces the final acuity result. It sits between the debounced key front end and the 8x8 dot-matrix renderer / 7-segment driver inside Vision_Test.

---
 rtl/vision_test_ctrl_if.sv | 26 ++
 rtl/vision_test_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vision_test_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vision_test_ctrl_if.sv
// rtl/vision_test_ctrl_if.sv - key inputs and display/result outputs of the vision test sequencer
interface vision_test_ctrl_if;
  logic       key_restart;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       disp_en;
  logic [1:0] dir;
  logic [2:0] level;
  logic       ans_valid;
  logic       ans_ok;
  logic       done;
  logic [2:0] result;
  logic [3:0] trial_cnt;

  modport master (
    output key_restart, key_up, key_down, key_left, key_right,
    input  disp_en, dir, level, ans_valid, ans_ok, done, result, trial_cnt
  );

  modport slave (
    input  key_restart, key_up, key_down, key_left, key_right,
    output disp_en, dir, level, ans_valid, ans_ok, done, result, trial_cnt
  );
endinterface

// File: rtl/vision_test_ctrl.sv
// rtl/vision_test_ctrl.sv - E-chart vision test sequencer: level stepping, response judging, acuity result
// Optional per-optotype response timeout is built when VT_TIMEOUT_EN is defined.
module vision_test_ctrl #(
  parameter int         BLANK_CYCLES   = 50,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter logic [2:0] START_LEVEL    = 3'd4
) (
  input logic               sys_clk,
  input logic               sys_rst,
  vision_test_ctrl_if.slave bus
);
  localparam int              BL_W     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_LAST  = BL_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]      LVL_MAX  = 3'd5;
  localparam logic [2:0]      LVL_FAIL = 3'd7;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK, DONE} state_t;
  typedef enum logic {DESC, ASC} mode_t;

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic            wrong_seen_q, wrong_seen_d;
  logic [7:0]      lfsr_q;
  logic [BL_W-1:0] blank_cnt_q, blank_cnt_d;
  logic            disp_en_q, disp_en_d;
  logic [1:0]      dir_q, dir_d;
  logic [2:0]      level_q, level_d;
  logic            ans_valid_q, ans_valid_d;
  logic            ans_ok_q, ans_ok_d;
  logic            done_q, done_d;
  logic [2:0]      result_q, result_d;
  logic [3:0]      trial_cnt_q, trial_cnt_d;

  logic [3:0] keys;
  logic       key_any;
  logic       key_hit;
  logic [1:0] cand;
  logic [1:0] draw_dir;
  logic       timeout_hit;
  logic       go_blank;
  logic       go_done;

  assign keys    = {bus.key_right, bus.key_left, bus.key_down, bus.key_up};
  assign key_any = |keys;
  assign key_hit = (keys == (4'b0001 << dir_q));

  // dir_q always holds the last drawn direction, so it doubles as prev_dir
  assign cand     = lfsr_q[1:0];
  assign draw_dir = (cand == dir_q) ? cand + 2'd1 : cand;

`ifdef VT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      to_cnt_q <= '0;
    end else if (state_d == SHOW && (state_q != SHOW || bus.key_restart)) begin
      to_cnt_q <= '0;
    end else if (state_q == SHOW) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == SHOW) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      mode_q       <= DESC;
      wrong_seen_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      blank_cnt_q  <= '0;
      disp_en_q    <= 1'b0;
      dir_q        <= 2'd0;
      level_q      <= START_LEVEL;
      ans_valid_q  <= 1'b0;
      ans_ok_q     <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 3'd0;
      trial_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wrong_seen_q <= wrong_seen_d;
      lfsr_q       <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      blank_cnt_q  <= blank_cnt_d;
      disp_en_q    <= disp_en_d;
      dir_q        <= dir_d;
      level_q      <= level_d;
      ans_valid_q  <= ans_valid_d;
      ans_ok_q     <= ans_ok_d;
      done_q       <= done_d;
      result_q     <= result_d;
      trial_cnt_q  <= trial_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    wrong_seen_d = wrong_seen_q;
    blank_cnt_d  = blank_cnt_q;
    disp_en_d    = disp_en_q;
    dir_d        = dir_q;
    level_d      = level_q;
    ans_valid_d  = 1'b0;
    ans_ok_d     = 1'b0;
    done_d       = done_q;
    result_d     = result_q;
    trial_cnt_d  = trial_cnt_q;
    go_blank     = 1'b0;
    go_done      = 1'b0;

    if (bus.key_restart) begin
      state_d      = SHOW;
      mode_d       = DESC;
      wrong_seen_d = 1'b0;
      disp_en_d    = 1'b1;
      dir_d        = draw_dir;
      level_d      = START_LEVEL;
      done_d       = 1'b0;
      trial_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        SHOW: begin
          if (key_any || timeout_hit) begin
            ans_valid_d = 1'b1;
            ans_ok_d    = key_hit;
            trial_cnt_d = (trial_cnt_q == 4'd15) ? trial_cnt_q : trial_cnt_q + 4'd1;
            if (mode_q == DESC) begin
              if (!key_hit) begin
                wrong_seen_d = 1'b1;
                if (level_q != 3'd0) begin
                  level_d  = level_q - 3'd1;
                  go_blank = 1'b1;
                end else begin
                  result_d = LVL_FAIL;
                  go_done  = 1'b1;
                end
              end else if (!wrong_seen_q) begin
                mode_d = ASC;
                if (level_q >= LVL_MAX) begin
                  result_d = LVL_MAX;
                  go_done  = 1'b1;
                end else begin
                  level_d  = level_q + 3'd1;
                  go_blank = 1'b1;
                end
              end else begin
                result_d = level_q;
                go_done  = 1'b1;
              end
            end else begin
              if (key_hit && level_q < LVL_MAX) begin
                level_d  = level_q + 3'd1;
                go_blank = 1'b1;
              end else if (key_hit) begin
                result_d = LVL_MAX;
                go_done  = 1'b1;
              end else begin
                // ascending run only starts after a pass, so level-1 is the last passed level
                result_d = level_q - 3'd1;
                go_done  = 1'b1;
              end
            end
          end
          if (go_blank) begin
            state_d     = BLANK;
            disp_en_d   = 1'b0;
            blank_cnt_d = '0;
          end
          if (go_done) begin
            state_d   = DONE;
            disp_en_d = 1'b0;
            done_d    = 1'b1;
          end
        end
        BLANK: begin
          if (blank_cnt_q == BL_LAST) begin
            state_d   = SHOW;
            disp_en_d = 1'b1;
            dir_d     = draw_dir;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.disp_en   = disp_en_q;
  assign bus.dir       = dir_q;
  assign bus.level     = level_q;
  assign bus.ans_valid = ans_valid_q;
  assign bus.ans_ok    = ans_ok_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.trial_cnt = trial_cnt_q;
endmodule

// File: tb/tb_vision_test_ctrl.sv
// tb/tb_vision_test_ctrl.sv - self-checking bench for vision_test_ctrl: vector table, hand sequences, random run vs model
module tb_vision_test_ctrl;
  localparam int         BLANK   = 4;
  localparam int         TIMEOUT = 20;
  localparam logic [7:0] SEED    = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vision_test_ctrl_if vif();

  vision_test_ctrl #(
    .BLANK_CYCLES  (BLANK),
    .TIMEOUT_CYCLES(TIMEOUT),
    .LFSR_SEED     (SEED),
    .START_LEVEL   (3'd4)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst_n),
    .bus    (vif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference direction source: the spec's 8-bit Fibonacci LFSR, taps 8,6,5,4
  logic [7:0] m_lfsr       = SEED;
  logic [7:0] lfsr_at_edge = SEED;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = SEED;
    end else begin
      lfsr_at_edge = m_lfsr;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  logic [1:0] m_dir = 2'd0;
  int m_level = 4, m_result = 0, m_trials = 0;
  bit m_asc = 0, m_wrong_seen = 0, m_done = 0;

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  ok_mask;
    logic [7:0]  dbl_mask;
    logic [23:0] exp_lv;
    int          exp_result;
    int          exp_trials;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [23:0] lvls(input int a, input int b, input int c, input int d, input int e);
    logic [2:0] la, lb, lc, ld, le;
    la = 3'(a); lb = 3'(b); lc = 3'(c); ld = 3'(d); le = 3'(e);
    return {9'd0, le, ld, lc, lb, la};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k, input logic rs);
    vif.key_up      = k[0];
    vif.key_down    = k[1];
    vif.key_left    = k[2];
    vif.key_right   = k[3];
    vif.key_restart = rs;
  endtask

  task automatic press(input logic [3:0] k, input logic rs);
    set_keys(k, rs);
    step();
    set_keys(4'b0000, 1'b0);
  endtask

  task automatic check_draw(input string name);
    logic [1:0] c, e;
    c = lfsr_at_edge[1:0];
    e = (c == m_dir) ? c + 2'd1 : c;
    check(name, vif.dir, e);
    m_dir = e;
  endtask

  task automatic model_restart();
    m_level = 4; m_asc = 0; m_wrong_seen = 0; m_done = 0; m_trials = 0;
  endtask

  task automatic model_judge(input bit ok);
    m_trials = (m_trials < 15) ? m_trials + 1 : 15;
    if (!m_asc) begin
      if (!ok) begin
        m_wrong_seen = 1;
        if (m_level > 0) m_level = m_level - 1;
        else begin m_result = 7; m_done = 1; end
      end else if (!m_wrong_seen) begin
        m_asc = 1;
        if (m_level == 5) begin m_result = 5; m_done = 1; end
        else m_level = m_level + 1;
      end else begin
        m_result = m_level; m_done = 1;
      end
    end else begin
      if (ok && m_level < 5) m_level = m_level + 1;
      else if (ok) begin m_result = 5; m_done = 1; end
      else begin m_result = m_level - 1; m_done = 1; end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_disp_en"}, vif.disp_en, 0);
    check({tag, "_dir"}, vif.dir, 0);
    check({tag, "_level"}, vif.level, 4);
    check({tag, "_ans_valid"}, vif.ans_valid, 0);
    check({tag, "_ans_ok"}, vif.ans_ok, 0);
    check({tag, "_done"}, vif.done, 0);
    check({tag, "_result"}, vif.result, 0);
    check({tag, "_trial_cnt"}, vif.trial_cnt, 0);
  endtask

  task automatic do_restart(input string tag);
    press(4'b0000, 1'b1);
    check_draw({tag, "_dir"});
    model_restart();
    check({tag, "_disp_en"}, vif.disp_en, 1);
    check({tag, "_level"}, vif.level, 4);
    check({tag, "_trials"}, vif.trial_cnt, 0);
    check({tag, "_done"}, vif.done, 0);
  endtask

  // kind: 0 wrong, 1/2 correct, 3 two keys at once
  task automatic respond(input int kind, input string tag);
    logic [1:0] d, w;
    logic [3:0] k;
    bit ok;
    d  = vif.dir;
    w  = d + 2'd1;
    ok = (kind == 1 || kind == 2);
    if (ok) k = 4'b0001 << d;
    else if (kind == 3) k = (4'b0001 << d) | (4'b0001 << w);
    else k = 4'b0001 << w;
    press(k, 1'b0);
    model_judge(ok);
    check({tag, "_ans_valid"}, vif.ans_valid, 1);
    check({tag, "_ans_ok"}, vif.ans_ok, int'(ok));
    check({tag, "_level"}, vif.level, m_level);
    check({tag, "_done"}, vif.done, int'(m_done));
    check({tag, "_trials"}, vif.trial_cnt, m_trials);
    check({tag, "_disp_en"}, vif.disp_en, 0);
    if (m_done) check({tag, "_result"}, vif.result, m_result);
  endtask

  task automatic wait_show(input bit stray, input string tag);
    int n;
    n = 0;
    while (vif.disp_en == 1'b0 && n < BLANK + 3) begin
      if (stray) set_keys(4'b0001 << $urandom_range(0, 3), 1'b0);
      step();
      set_keys(4'b0000, 1'b0);
      n++;
      check({tag, "_blank_no_ans"}, vif.ans_valid, 0);
    end
    check({tag, "_blank_len"}, n, BLANK);
    check_draw({tag, "_blank_dir"});
  endtask

  initial begin
    logic [1:0] prev;
    int n;

    vecs[0] = '{"always_wrong",      5, 8'b00000, 8'b00, lvls(4,3,2,1,0), 7, 5};
    vecs[1] = '{"wrong_then_right",  3, 8'b00100, 8'b00, lvls(4,3,2,0,0), 2, 3};
    vecs[2] = '{"always_right",      2, 8'b00011, 8'b00, lvls(4,5,0,0,0), 5, 2};
    vecs[3] = '{"right_then_wrong",  2, 8'b00001, 8'b00, lvls(4,5,0,0,0), 4, 2};
    vecs[4] = '{"double_then_right", 2, 8'b00010, 8'b01, lvls(4,3,0,0,0), 3, 2};
    vecs[5] = '{"wrong4_then_right", 5, 8'b10000, 8'b00, lvls(4,3,2,1,0), 0, 5};
    vecs[6] = '{"right_then_double", 2, 8'b00001, 8'b10, lvls(4,5,0,0,0), 4, 2};

    set_keys(4'b0000, 1'b0);
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    press(4'b0001, 1'b0);
    check("idle_key_no_ans", vif.ans_valid, 0);
    check("idle_disp_en", vif.disp_en, 0);

    for (int v = 0; v < 7; v++) begin
      do_restart({vecs[v].name, "_start"});
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i > 0) wait_show(i[0], vecs[v].name);
        check({vecs[v].name, "_lv_shown"}, vif.level, vecs[v].exp_lv[i*3 +: 3]);
        respond(vecs[v].dbl_mask[i] ? 3 : (vecs[v].ok_mask[i] ? 1 : 0), vecs[v].name);
        check({vecs[v].name, "_tbl_ok"}, vif.ans_ok, vecs[v].ok_mask[i]);
      end
      check({vecs[v].name, "_fin_done"}, vif.done, 1);
      check({vecs[v].name, "_fin_result"}, vif.result, vecs[v].exp_result);
      check({vecs[v].name, "_fin_trials"}, vif.trial_cnt, vecs[v].exp_trials);
      press(4'b0100, 1'b0);
      check({vecs[v].name, "_valid_drop"}, vif.ans_valid, 0);
      check({vecs[v].name, "_done_hold"}, vif.done, 1);
      check({vecs[v].name, "_result_hold"}, vif.result, vecs[v].exp_result);
    end

    // restart in the middle of BLANK
    do_restart("mid_blank");
    respond(0, "mid_blank_wrong");
    step();
    check("mid_blank_in_blank", vif.disp_en, 0);
    do_restart("mid_blank_restart");

    // restart wins over a simultaneous direction key
    press(4'b0001 << vif.dir, 1'b1);
    check_draw("rs_key_dir");
    model_restart();
    check("rs_key_no_ans", vif.ans_valid, 0);
    check("rs_key_trials", vif.trial_cnt, 0);
    check("rs_key_level", vif.level, 4);
    check("rs_key_disp", vif.disp_en, 1);

    for (int t = 0; t < 40; t++) begin
      do_restart("rand_start");
      for (int r = 0; r < 8 && !m_done; r++) begin
        if (r > 0) wait_show(1'b1, "rand");
        repeat ($urandom_range(0, 8)) begin
          step();
          check("rand_show_idle", vif.ans_valid, 0);
        end
        respond($urandom_range(0, 3), "rand");
      end
      check("rand_done", vif.done, 1);
      press(4'b0001 << $urandom_range(0, 3), 1'b0);
      check("rand_done_key_ignored", vif.ans_valid, 0);
      check("rand_done_hold", vif.done, 1);
      check("rand_result_hold", vif.result, m_result);
    end

    // asynchronous reset in SHOW with a key pending
    do_restart("async_rst");
    step();
    set_keys(4'b0001 << vif.dir, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst_imm");
    step();
    check("async_rst_no_ans", vif.ans_valid, 0);
    check("async_rst_trials", vif.trial_cnt, 0);
    set_keys(4'b0000, 1'b0);
    rst_n = 1'b1;
    m_dir = 2'd0;

    // back-to-back restarts: 1000 draws
    prev = vif.dir;
    set_keys(4'b0000, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      step();
      check_draw("draw_model");
      check("draw_no_repeat", int'(vif.dir != prev), 1);
      prev = vif.dir;
    end
    set_keys(4'b0000, 1'b0);

`ifdef VT_TIMEOUT_EN
    do_restart("timeout");
    n = 0;
    while (vif.ans_valid == 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycle", n, TIMEOUT);
    check("timeout_ans_ok", vif.ans_ok, 0);
    check("timeout_level", vif.level, 3);
    check("timeout_trials", vif.trial_cnt, 1);
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
